ac_snoop_capture: RTL and testbench

- Upstream stage of devil_in_fpga on the ACE snoop (AC) channel.
- Accepts AC requests from the interconnect, evaluates the snoop-type and address-window filters at acceptance, and buffers each request in a small FIFO with its match verdict.
- Presents requests to devil_in_fpga over a valid/ready interface and keeps saturating snoop and match counters for the status register.

---
 rtl/ac_snoop_capture_pkg.sv | 23 ++
 rtl/ac_snoop_capture_if.sv | 41 ++++
 rtl/ac_snoop_capture_fifo.sv | 53 +++++
 rtl/ac_snoop_capture.sv | 122 ++++++++++++
 tb/tb_ac_snoop_capture.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ac_snoop_capture_pkg.sv
// rtl/ac_snoop_capture_pkg.sv - shared types and constants for the AC snoop capture path
// AC_TIMESTAMP_EN adds a cycle timestamp field to each buffered request.
package devil_pkg;

    localparam logic [3:0] ACSNOOP_READONCE = 4'b0000;
    localparam logic [3:0] ACSNOOP_DVM      = 4'b1111;

    localparam int AC_FILTER_BIT   = 14;
    localparam int ADDR_FILTER_BIT = 15;

    // Address is held at the widest supported ACE address; the top slices it back down.
    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
        logic        match;
        logic        dvm;
`ifdef AC_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } ac_req_t;

endpackage

// File: rtl/ac_snoop_capture_if.sv
// rtl/ac_snoop_capture_if.sv - AC snoop input channel and buffered request output bundle
// AC_TIMESTAMP_EN adds o_req_ts.
interface ac_snoop_capture_if #(
    parameter int ADDR_W = 44
);
    logic              acvalid;
    logic              acready;
    logic [ADDR_W-1:0] acaddr;
    logic [3:0]        acsnoop;
    logic [2:0]        acprot;

    logic              o_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] o_req_addr;
    logic [3:0]        o_req_snoop;
    logic [2:0]        o_req_prot;
    logic              o_req_match;
    logic              o_req_dvm;
`ifdef AC_TIMESTAMP_EN
    logic [31:0]       o_req_ts;
`endif

    modport slave (
        input  acvalid, acaddr, acsnoop, acprot, i_req_ready,
        output acready, o_req_valid, o_req_addr, o_req_snoop, o_req_prot,
               o_req_match, o_req_dvm
`ifdef AC_TIMESTAMP_EN
        , output o_req_ts
`endif
    );

    modport master (
        output acvalid, acaddr, acsnoop, acprot, i_req_ready,
        input  acready, o_req_valid, o_req_addr, o_req_snoop, o_req_prot,
               o_req_match, o_req_dvm
`ifdef AC_TIMESTAMP_EN
        , input o_req_ts
`endif
    );

endinterface

// File: rtl/ac_snoop_capture_fifo.sv
// rtl/ac_snoop_capture_fifo.sv - synchronous request FIFO with flush, full/empty and level
// Head reads as zero while empty so the request outputs are clean after reset or flush.
module ac_req_fifo
    import devil_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_flush,
    input  logic    i_push,
    input  ac_req_t i_data,
    input  logic    i_pop,
    output ac_req_t o_head,
    output logic    o_full,
    output logic    o_empty,
    output logic [LW-1:0] o_level
);

    ac_req_t       r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ac_snoop_capture.sv
// rtl/ac_snoop_capture.sv - AC snoop acceptance, filtering, buffering and saturating counters
// AC_TIMESTAMP_EN stamps each accepted request with a free-running cycle count.
module ac_snoop_capture
    import devil_pkg::*;
#(
    parameter int C_ACE_ADDR_WIDTH   = 44,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH         = 4,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    ac_snoop_capture_if.slave             ac_if,
    input  logic                          i_ac_filter_en,
    input  logic                          i_addr_filter_en,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_acsnoop_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_base_addr_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_addr_size_reg,
    input  logic                          i_flush,
    input  logic                          i_cnt_clr,
    output logic [LW-1:0]                 o_fifo_level,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_snoop_cnt,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_match_cnt
);

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_pop;
    logic        w_dvm;
    logic        w_snoop_ok;
    logic        w_addr_ok;
    logic        w_match;
    logic [63:0] w_addr64;
    logic [32:0] w_win_end;
    ac_req_t     w_push_req;
    ac_req_t     w_head;
    logic        w_unused;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_snoop_cnt;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_match_cnt;

    // Flush also blocks acceptance so nothing lands in the FIFO being emptied.
    assign ac_if.acready = !w_full && !i_flush;
    assign w_accept      = ac_if.acvalid && ac_if.acready;
    assign w_pop         = !w_empty && ac_if.i_req_ready;

    assign w_dvm      = (ac_if.acsnoop == ACSNOOP_DVM);
    assign w_snoop_ok = !i_ac_filter_en || (ac_if.acsnoop == i_acsnoop_reg[3:0]);

    // Window end at 33 bits: a window touching the top of the 32-bit space never wraps.
    assign w_addr64  = 64'(ac_if.acaddr);
    assign w_win_end = {1'b0, i_base_addr_reg[31:0]} + {1'b0, i_addr_size_reg[31:0]};
    assign w_addr_ok = !i_addr_filter_en ||
                       ((w_addr64[63:32] == 32'd0) &&
                        (w_addr64[31:0] >= i_base_addr_reg[31:0]) &&
                        ({1'b0, w_addr64[31:0]} < w_win_end));

    assign w_match = w_snoop_ok && w_addr_ok && !w_dvm;

`ifdef AC_TIMESTAMP_EN
    logic [31:0] r_ts;

    always_ff @(posedge ace_aclk) begin
        if (ace_areset) r_ts <= '0;
        else            r_ts <= r_ts + 32'd1;
    end
`endif

    always_comb begin
        w_push_req       = '0;
        w_push_req.addr  = w_addr64;
        w_push_req.snoop = ac_if.acsnoop;
        w_push_req.prot  = ac_if.acprot;
        w_push_req.match = w_match;
        w_push_req.dvm   = w_dvm;
`ifdef AC_TIMESTAMP_EN
        w_push_req.ts    = r_ts;
`endif
    end

    ac_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ace_aclk),
        .rst     (ace_areset),
        .i_flush (i_flush),
        .i_push  (w_accept),
        .i_data  (w_push_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    assign ac_if.o_req_valid = !w_empty;
    assign ac_if.o_req_addr  = w_head.addr[C_ACE_ADDR_WIDTH-1:0];
    assign ac_if.o_req_snoop = w_head.snoop;
    assign ac_if.o_req_prot  = w_head.prot;
    assign ac_if.o_req_match = w_head.match;
    assign ac_if.o_req_dvm   = w_head.dvm;
`ifdef AC_TIMESTAMP_EN
    assign ac_if.o_req_ts    = w_head.ts;
`endif

    always_ff @(posedge ace_aclk) begin
        if (ace_areset || i_cnt_clr) begin
            r_snoop_cnt <= '0;
            r_match_cnt <= '0;
        end else if (w_accept) begin
            if (r_snoop_cnt != '1)            r_snoop_cnt <= r_snoop_cnt + 1'b1;
            if (w_match && r_match_cnt != '1) r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign o_snoop_cnt = r_snoop_cnt;
    assign o_match_cnt = r_match_cnt;

    assign w_unused = ^{i_acsnoop_reg, i_base_addr_reg, i_addr_size_reg, w_head};

endmodule

// File: tb/tb_ac_snoop_capture.sv
// tb/tb_ac_snoop_capture.sv - directed bench for ac_snoop_capture (filters, backpressure, counters, flush, reset)
module tb_ac_snoop_capture;
    import devil_pkg::*;

    localparam int AW    = 44;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          ace_aclk = 1'b0;
    logic          ace_areset;
    logic          i_ac_filter_en;
    logic          i_addr_filter_en;
    logic [DW-1:0] i_acsnoop_reg;
    logic [DW-1:0] i_base_addr_reg;
    logic [DW-1:0] i_addr_size_reg;
    logic          i_flush;
    logic          i_cnt_clr;
    logic [LW-1:0] o_fifo_level;
    logic [DW-1:0] o_snoop_cnt;
    logic [DW-1:0] o_match_cnt;

    int n_pass  = 0;
    int n_total = 0;

    ac_snoop_capture_if #(.ADDR_W(AW)) ac_if ();

    ac_snoop_capture #(
        .C_ACE_ADDR_WIDTH   (AW),
        .C_S_AXI_DATA_WIDTH (DW),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .ace_aclk         (ace_aclk),
        .ace_areset       (ace_areset),
        .ac_if            (ac_if.slave),
        .i_ac_filter_en   (i_ac_filter_en),
        .i_addr_filter_en (i_addr_filter_en),
        .i_acsnoop_reg    (i_acsnoop_reg),
        .i_base_addr_reg  (i_base_addr_reg),
        .i_addr_size_reg  (i_addr_size_reg),
        .i_flush          (i_flush),
        .i_cnt_clr        (i_cnt_clr),
        .o_fifo_level     (o_fifo_level),
        .o_snoop_cnt      (o_snoop_cnt),
        .o_match_cnt      (o_match_cnt)
    );

    always #5 ace_aclk = ~ace_aclk;

    typedef struct {
        logic        ac_f;
        logic        ad_f;
        logic [31:0] sreg;
        logic [31:0] base;
        logic [31:0] size;
        logic [43:0] addr;
        logic [3:0]  snoop;
        logic        exp_match;
        logic        exp_dvm;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge ace_aclk);
        #1;
    endtask

    initial begin
        int exp_m;
        int n_acc;

        vecs[0] = '{1'b0, 1'b0, 32'd0, 32'd0,          32'd0,     44'h40,          4'h0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd0, 32'd0,          32'd10,    44'd9,           4'h0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'd0, 32'd0,          32'd10,    44'd10,          4'h0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd0, 32'd0,          32'd0,     44'd0,           4'h0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'd1, 32'd0,          32'd0,     44'h80,          4'h0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'd1, 32'd0,          32'd0,     44'h80,          4'h1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'd0, 32'd0,          32'd0,     44'hC0,          4'hF, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'd0, 32'hFFFF_FFF0, 32'h20,    44'hFFFF_FFFF,   4'h0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 32'd0, 32'd0,          32'h100,   44'h1_0000_0010, 4'h0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 32'd0, 32'h1000,       32'h10,    44'hFFF,         4'h0, 1'b0, 1'b0};

        ace_areset       = 1'b1;
        i_ac_filter_en   = 1'b0;
        i_addr_filter_en = 1'b0;
        i_acsnoop_reg    = '0;
        i_base_addr_reg  = '0;
        i_addr_size_reg  = '0;
        i_flush          = 1'b0;
        i_cnt_clr        = 1'b0;
        ac_if.acvalid     = 1'b0;
        ac_if.acaddr      = '0;
        ac_if.acsnoop     = '0;
        ac_if.acprot      = '0;
        ac_if.i_req_ready = 1'b0;
        repeat (2) tick();
        ace_areset = 1'b0;
        #1;

        chk("rst_acready", 64'(ac_if.acready), 64'd1);
        chk("rst_valid", 64'(ac_if.o_req_valid), 64'd0);
        chk("rst_level", 64'(o_fifo_level), 64'd0);
        chk("rst_snoop_cnt", 64'(o_snoop_cnt), 64'd0);
        chk("rst_match_cnt", 64'(o_match_cnt), 64'd0);
        chk("rst_req_addr", 64'(ac_if.o_req_addr), 64'd0);

        exp_m = 0;
        for (int i = 0; i < 10; i++) begin
            i_ac_filter_en   = vecs[i].ac_f;
            i_addr_filter_en = vecs[i].ad_f;
            i_acsnoop_reg    = vecs[i].sreg;
            i_base_addr_reg  = vecs[i].base;
            i_addr_size_reg  = vecs[i].size;
            ac_if.acaddr     = vecs[i].addr;
            ac_if.acsnoop    = vecs[i].snoop;
            ac_if.acprot     = 3'(i);
            ac_if.acvalid    = 1'b1;
            #1;
            chk($sformatf("v%0d_no_fallthrough", i), 64'(ac_if.o_req_valid), 64'd0);
            tick();
            ac_if.acvalid = 1'b0;
            if (vecs[i].exp_match) exp_m++;
            chk($sformatf("v%0d_valid", i), 64'(ac_if.o_req_valid), 64'd1);
            chk($sformatf("v%0d_match", i), 64'(ac_if.o_req_match), 64'(vecs[i].exp_match));
            chk($sformatf("v%0d_dvm", i), 64'(ac_if.o_req_dvm), 64'(vecs[i].exp_dvm));
            chk($sformatf("v%0d_addr", i), 64'(ac_if.o_req_addr), 64'(vecs[i].addr));
            chk($sformatf("v%0d_prot", i), 64'(ac_if.o_req_prot), 64'(i % 8));
            chk($sformatf("v%0d_level", i), 64'(o_fifo_level), 64'd1);
            chk($sformatf("v%0d_snoop_cnt", i), 64'(o_snoop_cnt), 64'(i + 1));
            chk($sformatf("v%0d_match_cnt", i), 64'(o_match_cnt), 64'(exp_m));
            ac_if.i_req_ready = 1'b1;
            tick();
            ac_if.i_req_ready = 1'b0;
            chk($sformatf("v%0d_popped", i), 64'(ac_if.o_req_valid), 64'd0);
        end

        // Backpressure: fill the FIFO, then stall with ready+valid on a full FIFO.
        i_ac_filter_en   = 1'b0;
        i_addr_filter_en = 1'b0;
        ac_if.acsnoop    = 4'h0;
        ac_if.acvalid    = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            ac_if.acaddr = 44'h100 + 44'(k);
            #1;
            if (ac_if.acvalid && ac_if.acready) n_acc++;
            tick();
        end
        chk("full_accepts", 64'(n_acc), 64'd4);
        chk("full_acready", 64'(ac_if.acready), 64'd0);
        chk("full_level", 64'(o_fifo_level), 64'd4);
        chk("full_head", 64'(ac_if.o_req_addr), 64'h100);
        ac_if.acaddr      = 44'h105;
        ac_if.i_req_ready = 1'b1;
        #1;
        chk("full_pop_acready", 64'(ac_if.acready), 64'd0);
        tick();
        chk("full_pop_level", 64'(o_fifo_level), 64'd3);
        chk("full_pop_head", 64'(ac_if.o_req_addr), 64'h101);
        ac_if.acaddr = 44'h106;
        tick();
        chk("pushpop_level", 64'(o_fifo_level), 64'd3);
        chk("pushpop_head", 64'(ac_if.o_req_addr), 64'h102);
        ac_if.acvalid = 1'b0;
        repeat (2) tick();
        chk("drain_last", 64'(ac_if.o_req_addr), 64'h106);
        tick();
        ac_if.i_req_ready = 1'b0;
        chk("drain_level", 64'(o_fifo_level), 64'd0);

        // Clear wins over a same-cycle increment.
        i_cnt_clr     = 1'b1;
        ac_if.acaddr  = 44'h200;
        ac_if.acvalid = 1'b1;
        tick();
        i_cnt_clr     = 1'b0;
        ac_if.acvalid = 1'b0;
        chk("clr_snoop_cnt", 64'(o_snoop_cnt), 64'd0);
        chk("clr_match_cnt", 64'(o_match_cnt), 64'd0);
        chk("clr_level", 64'(o_fifo_level), 64'd1);
        ac_if.i_req_ready = 1'b1;
        tick();
        ac_if.i_req_ready = 1'b0;

        // Saturation of the match counter.
        force dut.r_match_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_match_cnt;
        ac_if.acvalid = 1'b1;
        tick();
        ac_if.acvalid = 1'b0;
        chk("sat_match_cnt", 64'(o_match_cnt), 64'hFFFF_FFFF);
        chk("sat_snoop_cnt", 64'(o_snoop_cnt), 64'd1);
        ac_if.i_req_ready = 1'b1;
        tick();
        ac_if.i_req_ready = 1'b0;

        // Flush with three buffered and a request pending.
        ac_if.acvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ac_if.acaddr = 44'h300 + 44'(k);
            tick();
        end
        chk("flush_pre_level", 64'(o_fifo_level), 64'd3);
        i_flush = 1'b1;
        #1;
        chk("flush_acready", 64'(ac_if.acready), 64'd0);
        tick();
        i_flush       = 1'b0;
        ac_if.acvalid = 1'b0;
        chk("flush_level", 64'(o_fifo_level), 64'd0);
        chk("flush_valid", 64'(ac_if.o_req_valid), 64'd0);
        chk("flush_snoop_cnt", 64'(o_snoop_cnt), 64'd4);

        // Reset mid-operation with two buffered.
        ac_if.acvalid = 1'b1;
        repeat (2) tick();
        ac_if.acvalid = 1'b0;
        chk("mid_pre_level", 64'(o_fifo_level), 64'd2);
        ace_areset = 1'b1;
        tick();
        ace_areset = 1'b0;
        #1;
        chk("mid_rst_level", 64'(o_fifo_level), 64'd0);
        chk("mid_rst_acready", 64'(ac_if.acready), 64'd1);
        chk("mid_rst_valid", 64'(ac_if.o_req_valid), 64'd0);
        chk("mid_rst_snoop_cnt", 64'(o_snoop_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
